// File: rtl/cipu_pkg.sv
// Shared types and defaults for the item stack/queue engine.
package cipu_pkg;

  // Top-level engine states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    POP,
    DRAIN
  } state_e;

  // Default stream control codes (ASCII ';', '$', '0').
  localparam logic [7:0] DEFAULT_DELIM_CODE = 8'd59;
  localparam logic [7:0] DEFAULT_END_CODE   = 8'd36;
  localparam logic [7:0] DEFAULT_ZERO_CODE  = 8'd48;

  // Width needed to hold any count from 0 to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cipu_out_stage.sv
// Registered valid/ready output slice holding out_data/out_last.
// A new beat may be loaded whenever the slice is empty or its current beat
// is being taken, so back-to-back beats flow without bubbles.
module cipu_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  output logic              ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  assign ready_o     = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

  // Load a new beat when the slot frees up; otherwise hold the presented beat.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (ready_o) begin
      valid_q <= push_i;
      if (push_i) begin
        data_q <= push_data_i;
        last_q <= push_last_i;
      end
    end
  end

endmodule

// File: rtl/cipu_stack_queue_engine.sv
// Item stack/queue engine: collects delimited groups of item codes into one
// storage array, pops a requested count of each group in LIFO order, keeps
// the rest, and drains everything kept in arrival order on the end code.
// Optional build macro CIPU_STATUS_EN adds occupancy and sticky overflow.
module cipu_stack_queue_engine
  import cipu_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 16,
  parameter int                CNT_W      = cnt_width(DEPTH),
  parameter logic [DATA_W-1:0] DELIM_CODE = DATA_W'(DEFAULT_DELIM_CODE),
  parameter logic [DATA_W-1:0] END_CODE   = DATA_W'(DEFAULT_END_CODE),
  parameter logic [DATA_W-1:0] ZERO_CODE  = DATA_W'(DEFAULT_ZERO_CODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  pop_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done_group,
  output logic              done_all
`ifdef CIPU_STATUS_EN
  ,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow
`endif
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  base_q, base_d;   // retained item count
  logic [CNT_W-1:0]  top_q, top_d;     // retained + current group
  logic [CNT_W-1:0]  rd_q, rd_d;       // next storage index to emit
  logic [CNT_W-1:0]  rem_q, rem_d;     // beats still to hand to the slice
  logic              zero_q, zero_d;   // current burst is the lone ZERO beat
  logic              done_group_q, done_group_d;
  logic              done_all_q, done_all_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;

  logic              in_fire, out_fire;
  logic              is_delim, is_end;
  logic [CNT_W-1:0]  grp_cnt, pop_n;

  logic              push, push_last, stage_ready;
  logic [DATA_W-1:0] push_data;

  assign in_ready   = ((state_q == IDLE) || (state_q == LOAD)) && !rst;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign is_delim   = (in_data == DELIM_CODE);
  assign is_end     = (in_data == END_CODE);
  assign grp_cnt    = top_q - base_q;
  assign pop_n      = (pop_num < grp_cnt) ? pop_num : grp_cnt;
  assign done_group = done_group_q;
  assign done_all   = done_all_q;

  // Next-state, storage write and output-slice feed for the engine FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    base_d       = base_q;
    top_d        = top_q;
    rd_d         = rd_q;
    rem_d        = rem_q;
    zero_d       = zero_q;
    done_group_d = 1'b0;
    done_all_d   = 1'b0;
    mem_we       = 1'b0;
    push         = 1'b0;
    push_data    = mem[rd_q[AW-1:0]];
    push_last    = (rem_q == ONE);

    case (state_q)
      IDLE, LOAD: begin
        if (in_fire) begin
          if (is_end) begin
            // Any open group joins the retained region; first drain beat
            // leaves in this same cycle.
            state_d = DRAIN;
            base_d  = top_q;
            push    = 1'b1;
            if (top_q == '0) begin
              push_data = ZERO_CODE;
              push_last = 1'b1;
              rem_d     = '0;
              zero_d    = 1'b1;
            end else begin
              push_data = mem[0];
              push_last = (top_q == ONE);
              rd_d      = ONE;
              rem_d     = top_q - ONE;
              zero_d    = 1'b0;
            end
          end else if (is_delim) begin
            // First pop beat comes from the top of the current group.
            state_d = POP;
            push    = 1'b1;
            if (pop_n == '0) begin
              push_data = ZERO_CODE;
              push_last = 1'b1;
              rem_d     = '0;
              zero_d    = 1'b1;
            end else begin
              push_data = mem[top_q[AW-1:0] - 1'b1];
              push_last = (pop_n == ONE);
              rd_d      = top_q - TWO;
              rem_d     = pop_n - ONE;
              zero_d    = 1'b0;
            end
          end else begin
            state_d = LOAD;
            if (top_q < DEPTH_C) begin
              mem_we = 1'b1;
              top_d  = top_q + ONE;
            end
          end
        end
      end

      POP: begin
        if ((rem_q != '0) && stage_ready) begin
          push  = 1'b1;
          rd_d  = rd_q - ONE;
          rem_d = rem_q - ONE;
        end
        if (out_fire && !zero_q) begin
          top_d = top_q - ONE;
        end
        if (out_fire && out_last) begin
          // Unpopped group items stay put and become retained.
          base_d       = top_d;
          done_group_d = 1'b1;
          state_d      = LOAD;
        end
      end

      DRAIN: begin
        if ((rem_q != '0) && stage_ready) begin
          push  = 1'b1;
          rd_d  = rd_q + ONE;
          rem_d = rem_q - ONE;
        end
        if (out_fire && out_last) begin
          base_d     = '0;
          top_d      = '0;
          done_all_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Engine state registers and registered done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      top_q        <= '0;
      rd_q         <= '0;
      rem_q        <= '0;
      zero_q       <= 1'b0;
      done_group_q <= 1'b0;
      done_all_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      top_q        <= top_d;
      rd_q         <= rd_d;
      rem_q        <= rem_d;
      zero_q       <= zero_d;
      done_group_q <= done_group_d;
      done_all_q   <= done_all_d;
    end
  end

  // Item storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; base/top define
    // which entries are meaningful, so stale contents are never emitted.
    if (mem_we) begin
      mem[top_q[AW-1:0]] <= in_data;
    end
  end

  cipu_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .push_last_i (push_last),
    .ready_o     (stage_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

`ifdef CIPU_STATUS_EN
  logic overflow_q;
  logic item_drop;

  assign item_drop = in_fire && !is_delim && !is_end && (top_q == DEPTH_C);
  assign occupancy = top_q;
  assign overflow  = overflow_q;

  // Sticky overflow flag, cleared when a drain completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (done_all_d) begin
      overflow_q <= 1'b0;
    end else if (item_drop) begin
      overflow_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cipu_stack_queue_engine.sv
// Directed bench for cipu_stack_queue_engine (DATA_W=8, DEPTH=16).
module tb_cipu_stack_queue_engine;

  typedef logic [7:0] byte_q_t [$];

  localparam logic [7:0] DELIM = 8'd59;
  localparam logic [7:0] ENDC  = 8'd36;
  localparam logic [7:0] ZERO  = 8'd48;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] pop_num;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       done_group;
  logic       done_all;
`ifdef CIPU_STATUS_EN
  logic [4:0] occupancy;
  logic       overflow;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int ng    = 0;
  int na    = 0;
  int stall_err = 0;
  byte_q_t got_data;
  logic    got_last [$];

  cipu_stack_queue_engine #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .pop_num    (pop_num),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .done_group (done_group),
    .done_all   (done_all)
`ifdef CIPU_STATUS_EN
    ,
    .occupancy  (occupancy),
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor on the falling edge: record beats that will transfer on the next
  // rising edge, count done pulses and flag any change during a stall.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (done_group) ng++;
      if (done_all)   na++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] d, input logic [4:0] pn);
    logic ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    pop_num  = pn;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the burst's done pulse, then compare the collected beats.
  task automatic finish_burst(input string tag, input bit is_end, input int pre, input byte_q_t exp);
    int seen;
    seen = pre;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      seen = is_end ? na : ng;
      if (seen != pre) break;
    end
    @(negedge clk);
    #1;
    seen = is_end ? na : ng;
    check({tag, " done pulses"}, 32'(seen - pre), 1);
    check({tag, " beat count"}, 32'(got_data.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_data.size()) begin
        check($sformatf("%s data[%0d]", tag, i), 32'(got_data[i]), 32'(exp[i]));
        check($sformatf("%s last[%0d]", tag, i), 32'(got_last[i]), 32'(i == exp.size() - 1));
      end
    end
    check({tag, " in_ready after"}, 32'(in_ready), 1);
  endtask

  task automatic run_burst(input string tag, input logic [7:0] code, input logic [4:0] pn,
                           input byte_q_t exp);
    int pre;
    bit is_end;
    is_end = (code == ENDC);
    pre    = is_end ? na : ng;
    got_data.delete();
    got_last.delete();
    send_beat(code, pn);
    check({tag, " first beat latency"}, 32'(out_valid), 1);
    finish_burst(tag, is_end, pre, exp);
  endtask

  initial begin
    byte_q_t e;
    int pre;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    pop_num   = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", 32'(out_data), 0);
    check("reset out_last", 32'(out_last), 0);
    check("reset done_group", 32'(done_group), 0);
    check("reset done_all", 32'(done_all), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready after reset", 32'(in_ready), 1);

    // A,B,C ; pop 2 -> C,B then drain -> A
    send_beat("A", 0);
    send_beat("B", 0);
    send_beat("C", 0);
    e = '{"C", "B"};
    run_burst("s1 pop", DELIM, 5'd2, e);
    e = '{"A"};
    run_burst("s1 drain", ENDC, 5'd0, e);

    // X,Y ; pop 0 -> ZERO, drain -> X,Y
    send_beat("X", 0);
    send_beat("Y", 0);
    e = '{ZERO};
    run_burst("s2 pop0", DELIM, 5'd0, e);
    e = '{"X", "Y"};
    run_burst("s2 drain", ENDC, 5'd0, e);

    // P,Q ; pop 5 clamps to 2 -> Q,P, drain -> ZERO
    send_beat("P", 0);
    send_beat("Q", 0);
    e = '{"Q", "P"};
    run_burst("s3 clamp", DELIM, 5'd5, e);
    e = '{ZERO};
    run_burst("s3 drain", ENDC, 5'd0, e);

    // Backpressure for 3 cycles in the middle of a 3-beat pop.
    for (int i = 1; i <= 4; i++) send_beat(8'h10 + 8'(i), 0);
    e = '{8'h14, 8'h13, 8'h12};
    pre = ng;
    got_data.delete();
    got_last.delete();
    send_beat(DELIM, 5'd3);
    check("s4 first beat latency", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("s4 stall valid %0d", i), 32'(out_valid), 1);
      check($sformatf("s4 stall data %0d", i), 32'(out_data), 32'h13);
      check($sformatf("s4 stall in_ready %0d", i), 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    finish_burst("s4 pop", 1'b0, pre, e);
    check("s4 stall stability errors", 32'(stall_err), 0);
    e = '{8'h11};
    run_burst("s4 drain", ENDC, 5'd0, e);

    // 17 items: the 17th is dropped, drain gives the first 16 in order.
    for (int i = 0; i < 17; i++) send_beat(8'h40 + 8'(i), 0);
`ifdef CIPU_STATUS_EN
    check("s5 occupancy", 32'(occupancy), 16);
    check("s5 overflow", 32'(overflow), 1);
`endif
    e = {};
    for (int i = 0; i < 16; i++) e.push_back(8'h40 + 8'(i));
    run_burst("s5 drain", ENDC, 5'd0, e);
`ifdef CIPU_STATUS_EN
    check("s5 overflow cleared", 32'(overflow), 0);
    check("s5 occupancy cleared", 32'(occupancy), 0);
`endif

    // Reset during the second beat of a 3-beat pop.
    send_beat("a", 0);
    send_beat("b", 0);
    send_beat("c", 0);
    pre = ng;
    got_data.delete();
    got_last.delete();
    send_beat(DELIM, 5'd3);
    @(posedge clk);
    #1;
    check("s6 second beat", 32'(out_data), 32'("b"));
    rst = 1'b1;
    #1;
    check("s6 out_valid in reset", 32'(out_valid), 0);
    check("s6 out_last in reset", 32'(out_last), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("s6 in_ready after release", 32'(in_ready), 1);
    repeat (3) @(negedge clk);
    #1;
    check("s6 no done_group", 32'(ng - pre), 0);
    e = '{ZERO};
    run_burst("s6 drain", ENDC, 5'd0, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cipu_stack_queue_engine.md
Name: cipu_stack_queue_engine

Overview:
Parametrised successor to the team's item-handling LIFO/FIFO unit.
- Accepts a delimited stream of item codes per group into one storage array.
- On each group delimiter, pops a requested count of that group's items in LIFO order, with output backpressure.
- Retains the unpopped items; on the end code, drains every retained item in FIFO (arrival) order.
- Sits between the item-stream source and the downstream result consumer.

Parameters:
DATA_W, 8, item/code width in bits
DEPTH, 16, total storage entries (retained region plus current group)
CNT_W, $clog2(DEPTH+1), width of counts and pointers
DELIM_CODE, 59, group terminator (';'); the accompanying pop_num is sampled with this beat
END_CODE, 36, end of stream ('$'); triggers the drain
ZERO_CODE, 48, emitted once when a pop or drain has nothing to output ('0')

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input beat present
in_ready  out  1  block accepts input beat
in_data  in  DATA_W  item code, DELIM_CODE or END_CODE
pop_num  in  CNT_W  pop request; sampled only on an accepted DELIM_CODE beat
out_valid  out  1  output beat present (registered)
out_ready  in  1  consumer accepts output beat
out_data  out  DATA_W  popped or drained item (registered)
out_last  out  1  final beat of the current pop or drain burst
done_group  out  1  one-cycle pulse after the last pop beat is accepted
done_all  out  1  one-cycle pulse after the last drain beat is accepted

Behaviour:
- Storage model: mem[0..DEPTH-1]; base = retained count; top = base + current-group count.
- Reset (async): state IDLE; base=top=0; out_valid, out_data, out_last, done_group, done_all all 0.
- No input beat is accepted while rst is high.
- in_ready=1 in IDLE and LOAD only, including the first cycle after reset release; 0 in POP and DRAIN.
- Handshake on both ports: a beat transfers when valid&&ready. out_data/out_last are held stable while out_valid&&!out_ready.
- States and transitions:
  - IDLE: an accepted beat is processed exactly as in LOAD, same cycle.
  - LOAD, accepted data item with top<DEPTH: mem[top]<=in_data; top++.
  - LOAD, accepted data item with top==DEPTH: item dropped; stream continues.
  - LOAD, accepted DELIM_CODE: latch n = min(pop_num, top-base); go to POP.
  - LOAD, accepted END_CODE: go to DRAIN. Any open group's items (base..top) join the retained region unpopped.
- POP:
  - n>0: emit mem[top-1], mem[top-2], ... for n beats; top decrements per accepted beat; out_last on beat n.
  - n==0: emit one ZERO_CODE beat with out_last=1.
  - After the last beat is accepted: base<=top (remaining group items become retained, in arrival order); pulse done_group; go to LOAD.
- DRAIN:
  - Emit mem[0..base-1] in ascending order, out_last on the final beat.
  - If base==0: emit a single ZERO_CODE beat with out_last=1.
  - After the last beat is accepted: pulse done_all; base=top=0; go to IDLE.
- Latency: first out_valid appears the cycle after the accepted DELIM_CODE/END_CODE beat. With out_ready=1, one beat per cycle.
- Next-state output registration: there are no bubbles between consecutive burst beats.
- Reset mid-POP/DRAIN: the burst is aborted immediately, with no done pulse, and all state is cleared.

Optional Feature:
CIPU_STATUS_EN
- Defined: adds outputs occupancy[CNT_W] (= top) and overflow (sticky, set on any dropped item).
  - overflow is cleared by rst or by the done_all pulse.
- Undefined: neither port exists; items are still dropped silently when full.

Decomposition:
- Package cipu_pkg holds:
  - state enum {IDLE, LOAD, POP, DRAIN};
  - default code constants DELIM_CODE, END_CODE, ZERO_CODE;
  - the CNT_W helper function.
- One natural sub-module: cipu_out_stage, the registered valid/ready output slice holding out_data/out_last.

Test Plan (DATA_W=8, DEPTH=16):
- Push 'A','B','C', then ';' with pop_num=2, out_ready=1.
  - Outputs 'C','B'; out_last on 'B'; done_group pulse.
  - Then '$' -> 'A' with out_last; done_all pulse.
- 'X','Y',';' with pop_num=0 -> single 48 beat with out_last. Then '$' -> 'X','Y' in order.
- 'P','Q',';' with pop_num=5 -> clamped; exactly 'Q','P' emitted; then '$' -> single 48.
- Pop burst with out_ready held low 3 cycles mid-burst -> out_data stable; no beat lost or duplicated; in_ready=0 throughout.
- 17 items then '$' -> first 16 drained in order; 17th dropped. With CIPU_STATUS_EN: overflow=1 and occupancy=16 before the drain.
- Assert rst during the second beat of a 3-beat pop -> out_valid=0 immediately; after release, in_ready=1; a following '$' yields a single 48.
